// File: rtl/period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of a slow asynchronous
// signal in clk cycles, with a sticky timeout when no rise arrives in time.
module period_meter #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 16777215
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic             en_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise, fall, at_limit;

    assign rise     = sync2_q & ~dly_q;
    assign fall     = ~sync2_q & dly_q;
    assign at_limit = (count_q == TIMEOUT_CNT);

    // Synchronizer and edge-detect delay run regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            en_q    <= enable;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = MEASURE;
                MEASURE: if (!rise && at_limit) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d       = count_q;
        shadow_high_d = shadow_high_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        valid_d       = 1'b0;
        timeout_d     = timeout_q;
        if (enable && !en_q) timeout_d = 1'b0;
        if (!enable) begin
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: count_d = '0;
                ARM:  if (rise) count_d = ONE_CNT;
                MEASURE: begin
                    if (fall) shadow_high_d = count_q;
                    // A rise coinciding with the limit still counts as a valid period
                    if (rise) begin
                        period_d    = count_q;
                        high_time_d = shadow_high_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        count_d     = ONE_CNT;
                    end else if (at_limit) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                    end else begin
                        count_d = count_q + ONE_CNT;
                    end
                end
                default: count_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= '0;
            shadow_high_q <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            count_q       <= count_d;
            shadow_high_q <= shadow_high_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboarded bench for period_meter: directed sig_in trains queue expected
// measurements, a negedge monitor checks every period_valid pulse.
module tb_period_meter;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 120;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;

    typedef struct {
        int per;
        int hi;
        int tol;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic prev_vld = 1'b0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sig_in       (sig_in),
        .enable       (enable),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        n_cmp++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_rise(input int hi, input int lo);
        sig_in = 1'b1;
        tick(hi);
        sig_in = 1'b0;
        tick(lo);
    endtask

    task automatic push(input int per, input int hi, input int tol);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        e.tol = tol;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per valid pulse
    always @(negedge clk) begin
        if (reset_n === 1'b1 && period_valid === 1'b1) begin
            exp_t e;
            chk("valid_not_back_to_back", int'(prev_vld), 0, 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: period=%0d high_time=%0d expected no pulse at %0t",
                         period, high_time, $time);
            end else begin
                e = exp_q.pop_front();
                chk("period", int'(period), e.per, e.tol);
                chk("high_time", int'(high_time), e.hi, e.tol);
                chk("timeout_at_valid", int'(timeout), 0, 0);
            end
        end
        prev_vld = (reset_n === 1'b1) ? period_valid : 1'b0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        #2;
        chk("rst_period", int'(period), 0, 0);
        chk("rst_high_time", int'(high_time), 0, 0);
        chk("rst_valid", int'(period_valid), 0, 0);
        chk("rst_timeout", int'(timeout), 0, 0);
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Disabled: rises are ignored
        do_rise(20, 40);
        do_rise(20, 40);
        chk("disabled_period", int'(period), 0, 0);

        // Steady 100/30 train; first rise only arms
        enable = 1'b1;
        tick(3);
        do_rise(30, 70);
        repeat (3) begin
            push(100, 30, 0);
            do_rise(30, 70);
        end
        // Last rise, then hold low: timeout exactly TIMEOUT cycles after detection
        push(100, 30, 0);
        sig_in = 1'b1;
        tick(30);
        sig_in = 1'b0;
        tick(92);
        chk("timeout_before_limit", int'(timeout), 0, 0);
        tick(1);
        chk("timeout_at_limit", int'(timeout), 1, 0);
        chk("timeout_hold_period", int'(period), 100, 0);
        chk("timeout_hold_high", int'(high_time), 30, 0);

        // Back in ARM: first rise arms, second 40 later measures and clears timeout
        do_rise(15, 25);
        push(40, 15, 0);
        do_rise(15, 105);
        chk("timeout_cleared", int'(timeout), 0, 0);
        // Period exactly TIMEOUT is valid; TIMEOUT+1 times out instead
        push(120, 15, 0);
        do_rise(15, 106);
        do_rise(15, 106);
        chk("timeout_over_limit", int'(timeout), 1, 0);

        // enable low holds outputs; enable rising clears timeout
        enable = 1'b0;
        tick(2);
        chk("disable_hold_timeout", int'(timeout), 1, 0);
        chk("disable_hold_period", int'(period), 120, 0);
        enable = 1'b1;
        tick(2);
        chk("reenable_clears_timeout", int'(timeout), 0, 0);
        do_rise(30, 70);
        push(100, 30, 0);
        do_rise(30, 70);
        push(100, 30, 0);
        sig_in = 1'b1;
        tick(20);
        enable = 1'b0;
        tick(10);
        sig_in = 1'b0;
        tick(70);
        do_rise(30, 70);
        chk("disabled_hold_period", int'(period), 100, 0);
        chk("disabled_hold_high", int'(high_time), 30, 0);
        enable = 1'b1;
        do_rise(30, 70);
        push(100, 30, 0);
        do_rise(30, 70);

        // Asynchronous reset mid-measurement
        push(100, 30, 0);
        sig_in = 1'b1;
        tick(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_period", int'(period), 0, 0);
        chk("async_rst_high", int'(high_time), 0, 0);
        chk("async_rst_valid", int'(period_valid), 0, 0);
        chk("async_rst_timeout", int'(timeout), 0, 0);
        sig_in = 1'b0;
        #2;
        reset_n = 1'b1;
        tick(3);
        do_rise(20, 40);
        push(60, 20, 0);
        do_rise(20, 40);
        chk("post_rst_period", int'(period), 60, 0);

        // Random phase against clk: +/-1 cycle tolerance
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) push(100, 30, 1);
            ph = $urandom_range(1, 9);
            #(ph);
            sig_in = 1'b1;
            #300;
            sig_in = 1'b0;
            #(700 - ph);
        end
        tick(10);
        chk("scoreboard_drained", exp_q.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the cycle counter and of the result outputs.
REQ-002 SHALL have parameter TIMEOUT, default 16777215, the maximum measurable period in clk cycles; legal range 2 to 2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sig_in  input  1  slow signal to measure, asynchronous to clk (e.g. a divided clock).
REQ-006 SHALL have port enable  input  1  measurement enable, synchronous to clk.
REQ-007 SHALL have port period  output  CNT_W  last measured rise-to-rise interval, in clk cycles.
REQ-008 SHALL have port high_time  output  CNT_W  rise-to-fall interval belonging to the same measurement as period.
REQ-009 SHALL have port period_valid  output  1  one-cycle pulse, high when period and high_time update.
REQ-010 SHALL have port timeout  output  1  sticky flag, high when no rise has occurred within TIMEOUT cycles.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a third delay flop; rise = sync & ~delay; fall = ~sync & delay.
REQ-012 SHALL implement FSM states IDLE, ARM, MEASURE, with all outputs registered.
REQ-013 IDLE: enable=1 -> ARM; the counter is held at 0.
REQ-014 ARM: rise -> MEASURE with count<=1; no output update.
REQ-015 MEASURE: count increments by 1 each cycle, so count = cycles since the last rise.
REQ-016 MEASURE, fall: shadow_high<=count.
REQ-017 MEASURE, rise: period<=count, high_time<=shadow_high, period_valid<=1, timeout<=0, count<=1, remain in MEASURE.
REQ-018 MEASURE, count==TIMEOUT with no rise in that cycle: timeout<=1, count<=0, -> ARM; period and high_time are held.
REQ-019 A rise in the same cycle as count==TIMEOUT SHALL win: a valid measurement with period=TIMEOUT.
REQ-020 enable=0 in any state SHALL force IDLE next cycle, clear count, suppress period_valid, and hold period, high_time and timeout; enable wins over a simultaneous rise.
REQ-021 enable rising from 0 SHALL clear timeout.
REQ-022 After entering ARM, the first rise only arms; the second rise produces the first valid.
REQ-023 Latency: a sig_in rising edge sampled at clk edge N SHALL produce period_valid high after edge N+2, for exactly one cycle.
REQ-024 count SHALL never wrap; REQ-018 bounds it at TIMEOUT.
REQ-025 period_valid SHALL never be high for two consecutive cycles; the minimum legal sig_in high or low time is 2 clk cycles.

Reset
REQ-026 reset_n=0 SHALL immediately clear period, high_time, period_valid, timeout, count, shadow_high and synchronizer flops, and force IDLE, independent of clk.
REQ-027 After reset_n deasserts, the block SHALL take no action until enable=1; two rises are needed before the first valid.
REQ-028 Reset asserted mid-MEASURE SHALL discard the partial measurement; no period_valid for it.

Verification
REQ-029 enable=1, sig_in period 100 clk, high 30 -> first rise no pulse; every later rise: period=100, high_time=30, one-cycle period_valid, timeout=0.
REQ-030 TIMEOUT=50, one rise then sig_in held low -> timeout=1 exactly 50 cycles after the rise detection, state ARM, period unchanged; two later rises 40 apart -> period=40, timeout=0.
REQ-031 TIMEOUT=50, sig_in period exactly 50 -> valid with period=50 and no timeout; period 51 -> timeout=1 and no valid.
REQ-032 enable dropped 20 cycles into a 100-cycle period -> no period_valid, outputs hold old values; re-enable -> first rise arms only, second rise gives period=100.
REQ-033 reset_n pulsed low mid-MEASURE between clk edges -> all outputs 0 before the next clk edge; no valid until two rises after enable.
REQ-034 sig_in toggled with a random phase against clk -> measured period within +/-1 of nominal; period_valid is never high on consecutive cycles.
